// File: rtl/pipe_skid_reg_if.sv
// Bus bundle for pipe_skid_reg: upstream/downstream handshake, payloads, flush and occupancy.
// slave is the register's view; master is the surrounding pipeline's view.
interface pipe_skid_reg_if #(
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned DATA_W = 117
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [1:0]        occupancy;

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready, flush,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport master (
    output in_valid, in_ctrl, in_data, out_ready, flush,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and 2-entry skid buffer.
// Define PIPE_REG_PERF_EN to add saturating stall_cnt / bubble_cnt counters.
module pipe_skid_reg #(
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned DATA_W = 117
`ifdef PIPE_REG_PERF_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic               clock,
  input  logic               rst,
  pipe_skid_reg_if.slave     bus
`ifdef PIPE_REG_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        occupancy_q, occupancy_d;
  logic              accept_c, pop_c;

  assign accept_c = bus.in_valid & in_ready_q;
  assign pop_c    = out_valid_q & bus.out_ready;

  // State register; all status outputs are registered alongside it
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q     <= EMPTY;
      m_ctrl_q    <= '0;
      m_data_q    <= '0;
      s_ctrl_q    <= '0;
      s_data_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      m_ctrl_q    <= m_ctrl_d;
      m_data_q    <= m_data_d;
      s_ctrl_q    <= s_ctrl_d;
      s_data_q    <= s_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occupancy_q <= occupancy_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept_c) state_d = HALF;
        HALF: begin
          if (accept_c && !pop_c)      state_d = FULL;
          else if (pop_c && !accept_c) state_d = EMPTY;
        end
        FULL:    if (pop_c) state_d = HALF;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Datapath and status; m_ctrl is kept zero whenever no head entry exists
  always_comb begin
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (bus.flush) begin
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_c) begin
            m_ctrl_d = bus.in_ctrl;
            m_data_d = bus.in_data;
          end
        end
        HALF: begin
          if (accept_c && pop_c) begin
            m_ctrl_d = bus.in_ctrl;
            m_data_d = bus.in_data;
          end else if (accept_c) begin
            s_ctrl_d = bus.in_ctrl;
            s_data_d = bus.in_data;
          end else if (pop_c) begin
            m_ctrl_d = '0;
          end
        end
        FULL: begin
          if (pop_c) begin
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
          end
        end
        default: ;
      endcase
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    case (state_d)
      HALF:    occupancy_d = 2'd1;
      FULL:    occupancy_d = 2'd2;
      default: occupancy_d = 2'd0;
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = m_ctrl_q;
  assign bus.out_data  = m_data_q;
  assign bus.occupancy = occupancy_q;

`ifdef PIPE_REG_PERF_EN
  // Saturating counters; flush deliberately does not clear them
  always_ff @(posedge clock) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid_q && !bus.out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid_q && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, counter sequence, and random run vs. a queue model.
module tb_pipe_skid_reg;
  localparam int unsigned CTRL_W = 9;
  localparam int unsigned DATA_W = 117;
`ifdef PIPE_REG_PERF_EN
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  pipe_skid_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();

  pipe_skid_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
`ifdef PIPE_REG_PERF_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
`ifdef PIPE_REG_PERF_EN
    , .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct {
    logic              r, iv, orr, fl;
    logic [CTRL_W-1:0] c;
    logic              e_ir, e_ov;
    logic [CTRL_W-1:0] e_oc;
    logic [1:0]        e_occ;
  } vec_t;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_of(input logic [CTRL_W-1:0] c);
    return {13{c}};
  endfunction

  function automatic vec_t v(input int r, iv, c, orr, fl, ir, ov, oc, occ);
    vec_t t;
    t.r = r[0]; t.iv = iv[0]; t.c = CTRL_W'(c); t.orr = orr[0]; t.fl = fl[0];
    t.e_ir = ir[0]; t.e_ov = ov[0]; t.e_oc = CTRL_W'(oc); t.e_occ = 2'(occ);
    return t;
  endfunction

  task automatic drive(input int r, iv, c, orr, fl);
    rst           = r[0];
    bus.in_valid  = iv[0];
    bus.in_ctrl   = CTRL_W'(c);
    bus.in_data   = data_of(CTRL_W'(c));
    bus.out_ready = orr[0];
    bus.flush     = fl[0];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  vec_t   t;
  entry_t q[$];
  entry_t e;
  logic   ir_m, acc, pop, r_i, iv_i, or_i, fl_i;
  logic [DATA_W-1:0] last_m;
  int     or_bias;
`ifdef PIPE_REG_PERF_EN
  int     stall_m, bubble_m;
`endif

  initial begin
    drive(0, 0, 0, 0, 0);

    // rows: rst, in_valid, ctrl, out_ready, flush | in_ready, out_valid, out_ctrl, occupancy
    tbl.push_back(v(0,0,0,0,0,   0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,   0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,   0,0,0,0));
    tbl.push_back(v(1,0,0,1,0,   1,0,0,0));
    tbl.push_back(v(1,1,1,1,0,   1,1,1,1));
    tbl.push_back(v(1,1,2,1,0,   1,1,2,1));
    tbl.push_back(v(1,1,3,1,0,   1,1,3,1));
    tbl.push_back(v(1,1,4,1,0,   1,1,4,1));
    tbl.push_back(v(1,0,0,1,0,   1,0,0,0));
    tbl.push_back(v(1,1,16,0,0,  1,1,16,1));
    tbl.push_back(v(1,1,17,0,0,  0,1,16,2));
    tbl.push_back(v(1,1,18,0,0,  0,1,16,2));
    tbl.push_back(v(1,1,18,1,0,  1,1,17,1));
    tbl.push_back(v(1,1,18,1,0,  1,1,18,1));
    tbl.push_back(v(1,0,0,0,0,   1,1,18,1));
    tbl.push_back(v(1,1,19,0,0,  0,1,18,2));
    tbl.push_back(v(1,1,20,0,1,  1,0,0,0));
    tbl.push_back(v(1,1,21,0,0,  1,1,21,1));
    tbl.push_back(v(1,1,22,0,0,  0,1,21,2));
    tbl.push_back(v(0,1,23,0,0,  0,0,0,0));
    tbl.push_back(v(1,1,24,1,0,  1,0,0,0));
    tbl.push_back(v(1,1,24,1,0,  1,1,24,1));
    tbl.push_back(v(1,0,0,1,0,   1,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      drive(int'(t.r), int'(t.iv), int'(t.c), int'(t.orr), int'(t.fl));
      step();
      chk($sformatf("vec%0d_in_ready", i),  128'(bus.in_ready),  128'(t.e_ir));
      chk($sformatf("vec%0d_out_valid", i), 128'(bus.out_valid), 128'(t.e_ov));
      chk($sformatf("vec%0d_out_ctrl", i),  128'(bus.out_ctrl),  128'(t.e_oc));
      chk($sformatf("vec%0d_occupancy", i), 128'(bus.occupancy), 128'(t.e_occ));
      if (t.e_ov || !t.r)
        chk($sformatf("vec%0d_out_data", i), 128'(bus.out_data), 128'(data_of(t.e_oc)));
    end

`ifdef PIPE_REG_PERF_EN
    drive(0, 0, 0, 0, 0); step();
    chk("perf_rst_stall",  128'(stall_cnt),  128'(0));
    chk("perf_rst_bubble", 128'(bubble_cnt), 128'(0));
    drive(1, 0, 0, 0, 0); step();
    drive(1, 1, 5, 0, 0); step();
    for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 0, 0); step(); end
    drive(1, 0, 0, 1, 0); step();
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 0, 0); step(); end
    // two empty cycles before the entry arrived, plus the three after it left
    chk("perf_stall_5",  128'(stall_cnt),  128'(5));
    chk("perf_bubble_5", 128'(bubble_cnt), 128'(5));
    drive(1, 1, 6, 0, 0); step();
    for (int i = 0; i < 20; i++) begin drive(1, 0, 0, 0, 0); step(); end
    chk("perf_stall_sat", 128'(stall_cnt),  128'(CNT_MAX));
    chk("perf_bubble_6",  128'(bubble_cnt), 128'(6));
`endif

    // random run against a queue model of the skid register
    q.delete();
    ir_m = 1'b0;
    last_m = '0;
    or_bias = 2;
`ifdef PIPE_REG_PERF_EN
    stall_m = 0;
    bubble_m = 0;
`endif
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) or_bias = int'($urandom_range(3));
      r_i  = (i == 0) ? 1'b0 : ($urandom_range(63) != 0);
      iv_i = ($urandom_range(3) != 0);
      or_i = ($urandom_range(3) < or_bias);
      fl_i = ($urandom_range(31) == 0);
      e.ctrl = CTRL_W'($urandom());
      e.data = DATA_W'({$urandom(), $urandom(), $urandom(), $urandom()});
      rst           = r_i;
      bus.in_valid  = iv_i;
      bus.in_ctrl   = e.ctrl;
      bus.in_data   = e.data;
      bus.out_ready = or_i;
      bus.flush     = fl_i;

      acc = iv_i && ir_m;
      pop = (q.size() > 0) && or_i;
`ifdef PIPE_REG_PERF_EN
      if (r_i) begin
        if (q.size() > 0 && !or_i && stall_m < CNT_MAX) stall_m++;
        if (q.size() == 0 && bubble_m < CNT_MAX) bubble_m++;
      end else begin
        stall_m = 0;
        bubble_m = 0;
      end
`endif
      if (!r_i) begin
        q.delete();
        ir_m = 1'b0;
        last_m = '0;
      end else if (fl_i) begin
        q.delete();
        ir_m = 1'b1;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
        ir_m = (q.size() < 2);
        if (q.size() > 0) last_m = q[0].data;
      end

      step();
      chk($sformatf("rnd%0d_in_ready", i),  128'(bus.in_ready),  128'(ir_m));
      chk($sformatf("rnd%0d_out_valid", i), 128'(bus.out_valid), 128'(q.size() > 0));
      chk($sformatf("rnd%0d_occupancy", i), 128'(bus.occupancy), 128'(q.size()));
      chk($sformatf("rnd%0d_out_ctrl", i),  128'(bus.out_ctrl),
          (q.size() > 0) ? 128'(q[0].ctrl) : 128'(0));
      chk($sformatf("rnd%0d_out_data", i),  128'(bus.out_data),  128'(last_m));
`ifdef PIPE_REG_PERF_EN
      chk($sformatf("rnd%0d_stall_cnt", i),  128'(stall_cnt),  128'(stall_m));
      chk($sformatf("rnd%0d_bubble_cnt", i), 128'(bubble_cnt), 128'(bubble_m));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
